approx_mult_err_monitor: RTL and testbench

- Synthesizable error-statistics collector for approximate-multiplier characterization. It is the receiving end of the stimulus/result stream.
- A sweep driver or on-chip pattern generator presents operand pairs with the approximate product through a valid/ready handshake.
- The block computes the exact product and accumulates error count, error-distance sum, maximum error distance and relative error distance. RED is scaled by 10000 and computed by a multi-cycle restoring divider.
- Results are readable as static outputs for on-board or emulation characterization of the multiplier library.

---
 rtl/approx_mult_err_monitor.sv | 193 +++++++++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor: accumulates error statistics for an approximate
// multiplier. Each accepted sample (a, b, r) is compared against the exact
// product; mismatches update the error count, error-distance sum, maximum
// error distance and a scaled relative error distance. The RED term comes
// from a restoring divider that produces one quotient bit per cycle.
//
// Handshake: a sample is taken on a rising edge where in_valid and in_ready
// are both high. in_ready is decoded from state (high only in IDLE); the
// source must hold its sample stable until that edge. clear in the same cycle
// suppresses acceptance.
module approx_mult_err_monitor #(
  parameter int W         = 4,
  parameter int CNT_W     = 16,
  parameter int ED_W      = 24,
  parameter int RED_W     = 32,
  parameter int RED_SCALE = 10000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [2*W-1:0]     in_r,
  output logic               busy,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [ED_W-1:0]    ed_sum,
  output logic [2*W-1:0]     max_ed,
  output logic [RED_W-1:0]   red_sum
);

  localparam int PW    = 2 * W;
  localparam int NUM_W = PW + 14;
  localparam int CW    = $clog2(NUM_W + 1);
  localparam logic [NUM_W-1:0] SCALE_N = NUM_W'(RED_SCALE);
  localparam logic [RED_W-1:0] SCALE_R = RED_W'(RED_SCALE);

  typedef enum logic [1:0] {IDLE, EVAL, DIV} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    r_q, r_d;
  logic [PW-1:0]    exact_q, exact_d;
  logic [PW:0]      rem_q, rem_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [ED_W-1:0]  ed_sum_q, ed_sum_d;
  logic [PW-1:0]    max_ed_q, max_ed_d;
  logic [RED_W-1:0] red_sum_q, red_sum_d;

  // Datapath helpers shared by the FSM
  logic [PW-1:0]    ed;
  logic [PW:0]      rem_sh;
  logic             q_bit;
  logic [PW:0]      rem_next;
  logic [NUM_W-1:0] quo_next;
  logic [CNT_W-1:0] sample_inc, err_inc;
  logic [ED_W:0]    ed_ext;
  logic [ED_W-1:0]  ed_sat;
  logic [RED_W-1:0] red_add;
  logic [RED_W:0]   red_ext;
  logic [RED_W-1:0] red_sat;

  // Error distance, one divider step and the saturating accumulator updates
  always_comb begin
    ed         = (r_q >= exact_q) ? (r_q - exact_q) : (exact_q - r_q);
    rem_sh     = {rem_q[PW-1:0], num_q[NUM_W-1]};
    q_bit      = (rem_sh >= {1'b0, exact_q});
    rem_next   = q_bit ? (rem_sh - {1'b0, exact_q}) : rem_sh;
    quo_next   = {quo_q[NUM_W-2:0], q_bit};
    sample_inc = (sample_count_q == '1) ? sample_count_q : sample_count_q + CNT_W'(1);
    err_inc    = (err_count_q == '1) ? err_count_q : err_count_q + CNT_W'(1);
    ed_ext     = {1'b0, ed_sum_q} + (ED_W+1)'(ed);
    ed_sat     = ed_ext[ED_W] ? '1 : ed_ext[ED_W-1:0];
    red_add    = (state_q == DIV) ? RED_W'(quo_next) : SCALE_R;
    red_ext    = {1'b0, red_sum_q} + {1'b0, red_add};
    red_sat    = red_ext[RED_W] ? '1 : red_ext[RED_W-1:0];
  end

  // Next-state and accumulator logic; clear overrides everything
  always_comb begin
    state_d        = state_q;
    r_d            = r_q;
    exact_d        = exact_q;
    rem_d          = rem_q;
    num_d          = num_q;
    quo_d          = quo_q;
    cnt_d          = cnt_q;
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    ed_sum_d       = ed_sum_q;
    max_ed_d       = max_ed_q;
    red_sum_d      = red_sum_q;
    if (clear) begin
      state_d        = IDLE;
      r_d            = '0;
      exact_d        = '0;
      rem_d          = '0;
      num_d          = '0;
      quo_d          = '0;
      cnt_d          = '0;
      sample_count_d = '0;
      err_count_d    = '0;
      ed_sum_d       = '0;
      max_ed_d       = '0;
      red_sum_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            r_d     = in_r;
            exact_d = PW'(in_a) * PW'(in_b);
            state_d = EVAL;
          end
        end
        EVAL: begin
          sample_count_d = sample_inc;
          state_d        = IDLE;
          if (ed != '0) begin
            err_count_d = err_inc;
            ed_sum_d    = ed_sat;
            if (ed > max_ed_q) max_ed_d = ed;
            if (exact_q == '0) begin
              // No defined ratio against a zero reference: charge one full scale
              red_sum_d = red_sat;
            end else begin
              num_d   = NUM_W'(ed) * SCALE_N;
              rem_d   = '0;
              quo_d   = '0;
              cnt_d   = '0;
              state_d = DIV;
            end
          end
        end
        DIV: begin
          rem_d = rem_next;
          quo_d = quo_next;
          num_d = {num_q[NUM_W-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NUM_W - 1)) begin
            red_sum_d = red_sat;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      r_q            <= '0;
      exact_q        <= '0;
      rem_q          <= '0;
      num_q          <= '0;
      quo_q          <= '0;
      cnt_q          <= '0;
      sample_count_q <= '0;
      err_count_q    <= '0;
      ed_sum_q       <= '0;
      max_ed_q       <= '0;
      red_sum_q      <= '0;
    end else begin
      state_q        <= state_d;
      r_q            <= r_d;
      exact_q        <= exact_d;
      rem_q          <= rem_d;
      num_q          <= num_d;
      quo_q          <= quo_d;
      cnt_q          <= cnt_d;
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      ed_sum_q       <= ed_sum_d;
      max_ed_q       <= max_ed_d;
      red_sum_q      <= red_sum_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign ed_sum       = ed_sum_q;
  assign max_ed       = max_ed_q;
  assign red_sum      = red_sum_q;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Bench for approx_mult_err_monitor: directed cases, sweeps, random samples,
// clear/reset mid-division and backpressure against a behavioural model.
module tb_approx_mult_err_monitor;
  localparam int W         = 4;
  localparam int CNT_W     = 16;
  localparam int ED_W      = 24;
  localparam int RED_W     = 32;
  localparam int RED_SCALE = 10000;
  localparam int PW        = 2 * W;
  localparam int DIV_LAT   = 2 * W + 14 + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic [PW-1:0]    in_r = '0;
  logic             busy;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;
  logic [ED_W-1:0]  ed_sum;
  logic [PW-1:0]    max_ed;
  logic [RED_W-1:0] red_sum;

  approx_mult_err_monitor #(
    .W(W), .CNT_W(CNT_W), .ED_W(ED_W), .RED_W(RED_W), .RED_SCALE(RED_SCALE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_r(in_r),
    .busy(busy), .sample_count(sample_count), .err_count(err_count),
    .ed_sum(ed_sum), .max_ed(max_ed), .red_sum(red_sum)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Scoreboard: expected in_ready-low cycle counts, one per accepted sample
  logic [31:0] exp_q[$];

  // Behavioural model totals
  longint m_cnt, m_err, m_ed, m_max, m_red;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int bits);
    longint lim;
    lim = (longint'(1) << bits) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_ed = 0; m_max = 0; m_red = 0;
    exp_q.delete();
  endtask

  // Applies one sample to the model; returns how many cycles in_ready stays low
  function automatic int model_sample(input int a, input int b, input int r);
    int exact, ed;
    exact = a * b;
    ed = (r > exact) ? r - exact : exact - r;
    m_cnt = sat(m_cnt + 1, CNT_W);
    if (ed == 0) return 1;
    m_err = sat(m_err + 1, CNT_W);
    m_ed  = sat(m_ed + ed, ED_W);
    if (ed > m_max) m_max = ed;
    if (exact == 0) begin
      m_red = sat(m_red + RED_SCALE, RED_W);
      return 1;
    end
    m_red = sat(m_red + (longint'(ed) * RED_SCALE) / exact, RED_W);
    return DIV_LAT;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_sample_count"}, sample_count, m_cnt);
    chk({tag, "_err_count"}, err_count, m_err);
    chk({tag, "_ed_sum"}, ed_sum, m_ed);
    chk({tag, "_max_ed"}, max_ed, m_max);
    chk({tag, "_red_sum"}, red_sum, m_red);
  endtask

  // Driver: presents a sample from a negedge and holds it until accepted
  task automatic accept(input int a, input int b, input int r);
    int guard;
    in_valid = 1'b1;
    in_a = W'(a);
    in_b = W'(b);
    in_r = PW'(r);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_in_ready", in_ready, 1);
    exp_q.push_back(32'(model_sample(a, b, r)));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts in_ready-low cycles after an acceptance and compares with the model
  task automatic wait_idle();
    int low;
    low = 0;
    while (!in_ready && low < 100) begin
      low++;
      @(negedge clk);
    end
    chk("ready_low_cycles", low, (exp_q.size() > 0) ? exp_q.pop_front() : -1);
    chk("busy_idle", busy, 0);
  endtask

  task automatic send(input int a, input int b, input int r);
    accept(a, b, r);
    wait_idle();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    check_all("clear");
  endtask

  initial begin
    int free_at, lat, a, b, r, guard;
    logic exp_ready;
    model_clear();

    // Reset
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact sample
    send(3, 5, 15);
    check_all("exact");

    // Under-estimate, fixed expectations plus model
    do_clear();
    send(3, 5, 13);
    chk("under_red_1333", red_sum, 1333);
    chk("under_ed_2", ed_sum, 2);
    check_all("under");

    // Over-estimate then zero reference
    do_clear();
    send(2, 2, 5);
    chk("over_red_2500", red_sum, 2500);
    send(0, 7, 1);
    chk("zero_red_12500", red_sum, 12500);
    chk("zero_err_2", err_count, 2);
    check_all("zero_ref");

    // Sample coinciding with clear is not accepted
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9; in_r = 8'd1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    model_clear();
    chk("clear_same_cycle_ready", in_ready, 1);
    check_all("clear_same_cycle");

    // Exhaustive sweep, exact model
    for (int i = 0; i < 256; i++) send(i / 16, i % 16, (i / 16) * (i % 16));
    chk("sweep_exact_count", sample_count, 256);
    check_all("sweep_exact");

    // Exhaustive sweep, off-by-one model
    do_clear();
    for (int i = 0; i < 256; i++) send(i / 16, i % 16, (i / 16) * (i % 16) + 1);
    chk("sweep_p1_err", err_count, 256);
    chk("sweep_p1_max", max_ed, 1);
    check_all("sweep_p1");

    // Random samples
    do_clear();
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      r = ($urandom_range(0, 3) == 0) ? a * b : $urandom_range(0, 255);
      send(a, b, r);
    end
    check_all("random");

    // Clear during DIV
    do_clear();
    accept(3, 5, 13);
    repeat (10) @(negedge clk);
    chk("mid_div_busy", busy, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    chk("mid_div_clear_ready", in_ready, 1);
    check_all("mid_div_clear");
    send(3, 5, 13);
    chk("after_clear_red", red_sum, 1333);

    // Asynchronous reset during DIV
    accept(2, 3, 7);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("async_rst_ready", in_ready, 1);
    chk("async_rst_busy", busy, 0);
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Backpressure: valid held high with data changing every cycle
    free_at = 0;
    for (int c = 0; c < 80; c++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      r = ($urandom_range(0, 1) == 0) ? a * b : $urandom_range(0, 255);
      in_valid = 1'b1; in_a = W'(a); in_b = W'(b); in_r = PW'(r);
      exp_ready = (c >= free_at);
      chk("bp_ready", in_ready, exp_ready);
      if (exp_ready) begin
        lat = model_sample(a, b, r);
        free_at = c + lat + 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_drain_ready", in_ready, 1);
    check_all("backpressure");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
